// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures ID-stage control, operands and specifiers for EX,
// converting StallFlush/BranchFlush into an EX bubble. Optional bubble counter: IDEX_BUBBLE_COUNT_EN.
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      StallFlush,
  input  logic                      BranchFlush,
  input  logic                      EX_Hold,
  input  logic                      ID_RegDst,
  input  logic                      ID_ALUSrc,
  input  logic                      ID_MemtoReg,
  input  logic                      ID_RegWrite,
  input  logic                      ID_MemoryRead,
  input  logic                      ID_MemoryWrite,
  input  logic                      ID_Branch,
  input  logic [1:0]                ID_ALUOp,
  input  logic [DATA_WIDTH-1:0]     ID_PCPlus4,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
  input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
  input  logic [DATA_WIDTH-1:0]     ID_Immediate,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rs,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rt,
  input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
  output logic                      EX_RegDst,
  output logic                      EX_ALUSrc,
  output logic                      EX_MemtoReg,
  output logic                      EX_RegWrite,
  output logic                      EX_MemoryRead,
  output logic                      EX_MemoryWrite,
  output logic                      EX_Branch,
  output logic [1:0]                EX_ALUOp,
  output logic [DATA_WIDTH-1:0]     EX_PCPlus4,
  output logic [DATA_WIDTH-1:0]     EX_ReadData1,
  output logic [DATA_WIDTH-1:0]     EX_ReadData2,
  output logic [DATA_WIDTH-1:0]     EX_Immediate,
  output logic [REG_ADDR_WIDTH-1:0] EX_rs,
  output logic [REG_ADDR_WIDTH-1:0] EX_rt,
  output logic [REG_ADDR_WIDTH-1:0] EX_rd,
`ifdef IDEX_BUBBLE_COUNT_EN
  output logic [15:0]               BubbleCount,
`endif
  output logic                      EX_Valid
);

  logic                      flush;
  logic [8:0]                id_ctl;
  logic [8:0]                ctl_d, ctl_q;
  logic [DATA_WIDTH-1:0]     pc_d, pc_q, rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic                      valid_d, valid_q;

  assign flush  = StallFlush | BranchFlush;
  assign id_ctl = {ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite,
                   ID_MemoryRead, ID_MemoryWrite, ID_Branch, ID_ALUOp};

  // Priority hold > flush > load; a flush zeroes control only, datapath still loads.
  always_comb begin
    ctl_d   = ctl_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    valid_d = valid_q;
    if (!EX_Hold) begin
      pc_d  = ID_PCPlus4;
      rd1_d = ID_ReadData1;
      rd2_d = ID_ReadData2;
      imm_d = ID_Immediate;
      rs_d  = ID_rs;
      rt_d  = ID_rt;
      rd_d  = ID_rd;
      if (flush) begin
        ctl_d   = 9'd0;
        valid_d = 1'b0;
      end else begin
        ctl_d   = id_ctl;
        valid_d = 1'b1;
      end
    end else begin
      ctl_d   = ctl_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q   <= 9'd0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ctl_q   <= ctl_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign {EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite,
          EX_MemoryRead, EX_MemoryWrite, EX_Branch, EX_ALUOp} = ctl_q;
  assign EX_PCPlus4   = pc_q;
  assign EX_ReadData1 = rd1_q;
  assign EX_ReadData2 = rd2_q;
  assign EX_Immediate = imm_q;
  assign EX_rs        = rs_q;
  assign EX_rt        = rt_q;
  assign EX_rd        = rd_q;
  assign EX_Valid     = valid_q;

`ifdef IDEX_BUBBLE_COUNT_EN
  logic [15:0] cnt_d, cnt_q;

  // Saturating count of applied flushes.
  always_comb begin
    cnt_d = cnt_q;
    if (!EX_Hold && flush && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign BubbleCount = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized self-checking bench for id_ex_register against a behavioural pipeline-slot model.
module tb_id_ex_register;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallFlush = 1'b0, BranchFlush = 1'b0, EX_Hold = 1'b0;
  logic        ID_RegDst = 1'b0, ID_ALUSrc = 1'b0, ID_MemtoReg = 1'b0, ID_RegWrite = 1'b0;
  logic        ID_MemoryRead = 1'b0, ID_MemoryWrite = 1'b0, ID_Branch = 1'b0;
  logic [1:0]  ID_ALUOp = 2'd0;
  logic [31:0] ID_PCPlus4 = 32'd0, ID_ReadData1 = 32'd0, ID_ReadData2 = 32'd0, ID_Immediate = 32'd0;
  logic [4:0]  ID_rs = 5'd0, ID_rt = 5'd0, ID_rd = 5'd0;
  logic        EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemoryRead, EX_MemoryWrite, EX_Branch;
  logic [1:0]  EX_ALUOp;
  logic [31:0] EX_PCPlus4, EX_ReadData1, EX_ReadData2, EX_Immediate;
  logic [4:0]  EX_rs, EX_rt, EX_rd;
  logic        EX_Valid;
`ifdef IDEX_BUBBLE_COUNT_EN
  logic [15:0] BubbleCount;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the EX slot: what instruction sits there and how many bubbles were made.
  typedef struct {
    bit          regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs, rt, rd;
    bit          valid;
    int          bubbles;
  } slot_t;
  slot_t m;

  id_ex_register dut (
    .clk(clk), .reset_n(reset_n), .StallFlush(StallFlush), .BranchFlush(BranchFlush), .EX_Hold(EX_Hold),
    .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemtoReg(ID_MemtoReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemoryRead(ID_MemoryRead), .ID_MemoryWrite(ID_MemoryWrite), .ID_Branch(ID_Branch), .ID_ALUOp(ID_ALUOp),
    .ID_PCPlus4(ID_PCPlus4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Immediate(ID_Immediate), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite),
    .EX_MemoryRead(EX_MemoryRead), .EX_MemoryWrite(EX_MemoryWrite), .EX_Branch(EX_Branch), .EX_ALUOp(EX_ALUOp),
    .EX_PCPlus4(EX_PCPlus4), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Immediate(EX_Immediate), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
`ifdef IDEX_BUBBLE_COUNT_EN
    .BubbleCount(BubbleCount),
`endif
    .EX_Valid(EX_Valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m = '{default: 0};
  endtask

  // Apply one clock edge to the model using the inputs the DUT sampled.
  task automatic model_edge();
    bit bubble;
    if (EX_Hold) return;
    bubble = StallFlush || BranchFlush;
    m.pc = ID_PCPlus4; m.r1 = ID_ReadData1; m.r2 = ID_ReadData2; m.imm = ID_Immediate;
    m.rs = ID_rs; m.rt = ID_rt; m.rd = ID_rd;
    m.valid    = !bubble;
    m.regdst   = bubble ? 1'b0 : ID_RegDst;
    m.alusrc   = bubble ? 1'b0 : ID_ALUSrc;
    m.memtoreg = bubble ? 1'b0 : ID_MemtoReg;
    m.regwrite = bubble ? 1'b0 : ID_RegWrite;
    m.memread  = bubble ? 1'b0 : ID_MemoryRead;
    m.memwrite = bubble ? 1'b0 : ID_MemoryWrite;
    m.branch   = bubble ? 1'b0 : ID_Branch;
    m.aluop    = bubble ? 2'd0 : ID_ALUOp;
    if (bubble && m.bubbles < 65535) m.bubbles++;
  endtask

  task automatic check_all();
    check("RegDst", {31'd0, EX_RegDst}, {31'd0, m.regdst});
    check("ALUSrc", {31'd0, EX_ALUSrc}, {31'd0, m.alusrc});
    check("MemtoReg", {31'd0, EX_MemtoReg}, {31'd0, m.memtoreg});
    check("RegWrite", {31'd0, EX_RegWrite}, {31'd0, m.regwrite});
    check("MemoryRead", {31'd0, EX_MemoryRead}, {31'd0, m.memread});
    check("MemoryWrite", {31'd0, EX_MemoryWrite}, {31'd0, m.memwrite});
    check("Branch", {31'd0, EX_Branch}, {31'd0, m.branch});
    check("ALUOp", {30'd0, EX_ALUOp}, {30'd0, m.aluop});
    check("PCPlus4", EX_PCPlus4, m.pc);
    check("ReadData1", EX_ReadData1, m.r1);
    check("ReadData2", EX_ReadData2, m.r2);
    check("Immediate", EX_Immediate, m.imm);
    check("rs", {27'd0, EX_rs}, {27'd0, m.rs});
    check("rt", {27'd0, EX_rt}, {27'd0, m.rt});
    check("rd", {27'd0, EX_rd}, {27'd0, m.rd});
    check("Valid", {31'd0, EX_Valid}, {31'd0, m.valid});
`ifdef IDEX_BUBBLE_COUNT_EN
    check("BubbleCount", {16'd0, BubbleCount}, m.bubbles);
`endif
  endtask

  task automatic step(input bit do_check);
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) check_all();
  endtask

  task automatic randomize_id();
    {ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemoryRead, ID_MemoryWrite, ID_Branch} = 7'($urandom);
    ID_ALUOp = 2'($urandom);
    ID_PCPlus4 = $urandom; ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_Immediate = $urandom;
    ID_rs = 5'($urandom); ID_rt = 5'($urandom); ID_rd = 5'($urandom);
  endtask

  task automatic set_ctl(input logic [8:0] c);
    {ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemoryRead, ID_MemoryWrite, ID_Branch, ID_ALUOp} = c;
  endtask

  // Pulse reset between edges and confirm outputs clear without a clock.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("reset_valid", {31'd0, EX_Valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Normal load.
    randomize_id();
    set_ctl(9'b0001_0000_0);
    ID_ReadData1 = 32'h0000_1234; ID_rt = 5'd9;
    step(1'b1);
    check("load_rd1", EX_ReadData1, 32'h0000_1234);
    check("load_rt", {27'd0, EX_rt}, 32'd9);
    check("load_regwrite", {31'd0, EX_RegWrite}, 32'd1);
    check("load_valid", {31'd0, EX_Valid}, 32'd1);

    // Asynchronous reset while EX_RegWrite is 1.
    mid_reset();

    // Load-use: lw $9 enters EX, dependent add stalls for one edge.
    set_ctl(9'b0111_1000_0); ID_rs = 5'd4; ID_rt = 5'd9; ID_Immediate = 32'd16;
    step(1'b1);
    check("lw_memread", {31'd0, EX_MemoryRead}, 32'd1);
    set_ctl(9'b1001_0000_0 | 9'd2); ID_rs = 5'd9; ID_rt = 5'd10; ID_rd = 5'd11;
    StallFlush = 1'b1;
    step(1'b1);
    check("bubble_regwrite", {31'd0, EX_RegWrite}, 32'd0);
    check("bubble_memread", {31'd0, EX_MemoryRead}, 32'd0);
    check("bubble_valid", {31'd0, EX_Valid}, 32'd0);
    check("bubble_rt", {27'd0, EX_rt}, 32'd10);
    StallFlush = 1'b0;
    step(1'b1);
    check("add_valid", {31'd0, EX_Valid}, 32'd1);
    check("add_aluop", {30'd0, EX_ALUOp}, 32'd2);
    check("add_regdst", {31'd0, EX_RegDst}, 32'd1);

    // Hold beats flush for three cycles with changing ID data.
    EX_Hold = 1'b1; BranchFlush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      step(1'b1);
      check("hold_valid", {31'd0, EX_Valid}, 32'd1);
      check("hold_rd", {27'd0, EX_rd}, 32'd11);
    end
    EX_Hold = 1'b0; BranchFlush = 1'b0;

    // Simultaneous flushes from a fresh reset: two bubbles.
    mid_reset();
    StallFlush = 1'b1; BranchFlush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randomize_id();
      step(1'b1);
      check("dual_valid", {31'd0, EX_Valid}, 32'd0);
    end
`ifdef IDEX_BUBBLE_COUNT_EN
    check("dual_count", {16'd0, BubbleCount}, 32'd2);
`endif
    StallFlush = 1'b0; BranchFlush = 1'b0;

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 400; i++) begin
      randomize_id();
      EX_Hold     = ($urandom_range(0, 3) == 0);
      StallFlush  = ($urandom_range(0, 3) == 0);
      BranchFlush = ($urandom_range(0, 7) == 0);
      step(1'b1);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end
    EX_Hold = 1'b0;

`ifdef IDEX_BUBBLE_COUNT_EN
    // Saturation: 65535 flushes from reset reach FFFF, two more stay there.
    mid_reset();
    StallFlush = 1'b1; BranchFlush = 1'b0;
    for (int i = 0; i < 65535; i++) step(1'b0);
    check_all();
    check("sat_full", {16'd0, BubbleCount}, 32'h0000_FFFF);
    for (int i = 0; i < 2; i++) step(1'b1);
    check("sat_hold", {16'd0, BubbleCount}, 32'h0000_FFFF);
    StallFlush = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
